// File: rtl/a2d_arb_pkg.sv
// Shared types for the A2D arbiter.
//   NUM_REQ : number of requesters sharing the converter
//   state_t : arbiter FSM states
//   chnl_t  : 3-bit A2D channel number
//   idx_t   : requester index (0..NUM_REQ-1)
package a2d_arb_pkg;

    localparam int NUM_REQ = 3;

    typedef logic [2:0] chnl_t;
    typedef logic [1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/a2d_arb_rr_pick.sv
// Combinational round-robin picker.
//   req      : per-requester request bits
//   last_gnt : requester served most recently
//   gnt      : winning requester index (0 when vld is low)
//   vld      : at least one request is pending
module rr_pick
    import a2d_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               last_gnt,
    output idx_t               gnt,
    output logic               vld
);

    // Walk the ring from farthest (last_gnt itself) to nearest
    // (last_gnt+1); the last hit written is the nearest, so it wins.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_gnt) + k) % NUM_REQ]) begin
                gnt = idx_t'((int'(last_gnt) + k) % NUM_REQ);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/a2d_arb.sv
// Arbiter sharing one A2D converter between three requesters
// (IR scan, battery, aux). Round-robin grant, one conversion per grant,
// with a timeout in case the converter never completes.
//   clk, rst       : clock, synchronous active-high reset
//   req            : per-requester conversion request
//   chnnl0..2      : channel each requester wants
//   cnv_cmplt, res : completion pulse and result from the converter
//   strt_cnv, chnnl: start pulse and channel to the converter
//   done           : one-hot completion pulse to the granted requester
//   res_out        : last captured result (held)
//   busy           : arbiter not idle
//   tmo            : grant ended by timeout (coincides with done)
module a2d_arb
    import a2d_arb_pkg::*;
#(
    parameter int TMO_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  chnl_t              chnnl0,
    input  chnl_t              chnnl1,
    input  chnl_t              chnnl2,
    input  logic               cnv_cmplt,
    input  logic [11:0]        res,
    output logic               strt_cnv,
    output chnl_t              chnnl,
    output logic [NUM_REQ-1:0] done,
    output logic [11:0]        res_out,
    output logic               busy,
    output logic               tmo
);

    localparam int              CW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0]   TMO_LAST = CW'(TMO_CYC - 1);

    state_t        state;
    idx_t          gnt;
    idx_t          last_gnt;
    idx_t          pick_gnt;
    logic          pick_vld;
    chnl_t         pick_ch;
    logic [CW-1:0] cnt;
    logic          flag;

    rr_pick u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt),
        .vld      (pick_vld)
    );

    always_comb begin
        pick_ch = chnnl0;
        case (pick_gnt)
            2'd1:    pick_ch = chnnl1;
            2'd2:    pick_ch = chnnl2;
            default: pick_ch = chnnl0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= 2'd2;   // requester 0 is first after reset
            chnnl    <= '0;
            res_out  <= '0;
            cnt      <= '0;
            flag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // chnnl only moves here, so it is stable START..DONE
                    if (pick_vld) begin
                        gnt   <= pick_gnt;
                        chnnl <= pick_ch;
                        state <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    flag  <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    // completion beats a coincident timeout
                    if (cnv_cmplt) begin
                        res_out <= res;
                        state   <= DONE;
                    end else if (cnt == TMO_LAST) begin
                        flag  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_gnt <= gnt;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs decoded from registered state
    assign strt_cnv = (state == START);
    assign done     = (state == DONE) ? (3'b001 << gnt) : '0;
    assign tmo      = (state == DONE) && flag;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_a2d_arb.sv
// Directed bench for a2d_arb. Two instances share stimulus: u_a uses the
// default timeout, u_b uses TMO_CYC=16 for the timeout scenarios.
module tb_a2d_arb;
    import a2d_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    chnl_t       chnnl0, chnnl1, chnnl2;
    logic        cnv_cmplt;
    logic [11:0] res;

    logic        strt_a, busy_a, tmo_a;
    chnl_t       ch_a;
    logic [2:0]  done_a;
    logic [11:0] ro_a;
    logic        strt_b, busy_b, tmo_b;
    chnl_t       ch_b;
    logic [2:0]  done_b;
    logic [11:0] ro_b;

    int vecs = 0;
    int errs = 0;

    a2d_arb u_a (
        .clk(clk), .rst(rst), .req(req),
        .chnnl0(chnnl0), .chnnl1(chnnl1), .chnnl2(chnnl2),
        .cnv_cmplt(cnv_cmplt), .res(res),
        .strt_cnv(strt_a), .chnnl(ch_a), .done(done_a),
        .res_out(ro_a), .busy(busy_a), .tmo(tmo_a)
    );

    a2d_arb #(.TMO_CYC(16)) u_b (
        .clk(clk), .rst(rst), .req(req),
        .chnnl0(chnnl0), .chnnl1(chnnl1), .chnnl2(chnnl2),
        .cnv_cmplt(cnv_cmplt), .res(res),
        .strt_cnv(strt_b), .chnnl(ch_b), .done(done_b),
        .res_out(ro_b), .busy(busy_b), .tmo(tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; chnnl0 = '0; chnnl1 = '0; chnnl2 = '0;
        cnv_cmplt = 1'b0; res = '0;
        tick();
        tick();
        // reset state
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_strt",  32'(strt_a), 32'd0);
        chk("rst_done",  32'(done_a), 32'd0);
        chk("rst_tmo",   32'(tmo_a),  32'd0);
        chk("rst_chnnl", 32'(ch_a),   32'd0);
        chk("rst_res",   32'(ro_a),   32'd0);
        chk("rst_busy_b",32'(busy_b), 32'd0);
        rst = 1'b0;

        // single request, completion 40 cycles after start
        req = 3'b001; chnnl0 = 3'd5;
        chk("idle_strt", 32'(strt_a), 32'd0);
        tick();
        chk("t1_strt",  32'(strt_a), 32'd1);
        chk("t1_chnnl", 32'(ch_a),   32'd5);
        chk("t1_busy",  32'(busy_a), 32'd1);
        tick();
        chk("t1_strt_pulse", 32'(strt_a), 32'd0);
        for (int i = 0; i < 38; i++) tick();
        chk("t1_wait_done", 32'(done_a), 32'd0);
        tick();
        cnv_cmplt = 1'b1; res = 12'hA5C;
        tick();
        cnv_cmplt = 1'b0; res = '0;
        chk("t1_done",  32'(done_a), 32'b001);
        chk("t1_res",   32'(ro_a),   32'hA5C);
        chk("t1_tmo",   32'(tmo_a),  32'd0);
        chk("t1_chnnl_hold", 32'(ch_a), 32'd5);
        req = 3'b000;
        tick();
        chk("t1_idle_busy", 32'(busy_a), 32'd0);
        chk("t1_idle_done", 32'(done_a), 32'd0);
        chk("t1_res_hold",  32'(ro_a),   32'hA5C);

        // all three requesting: grant order 0,1,2,0,1,2
        do_reset();
        req = 3'b111; chnnl0 = 3'd1; chnnl1 = 3'd2; chnnl2 = 3'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_strt",  32'(strt_a), 32'd1);
            chk("rr_chnnl", 32'(ch_a),   32'((i % 3) + 1));
            tick();
            cnv_cmplt = 1'b1; res = 12'(16 * i + 1);
            tick();
            cnv_cmplt = 1'b0;
            chk("rr_done",  32'(done_a), 32'(3'b001 << (i % 3)));
            chk("rr_res",   32'(ro_a),   32'(16 * i + 1));
            tick();
        end
        req = 3'b000;
        tick();

        // completion on the last WAIT cycle before timeout (TMO_CYC=16)
        do_reset();
        req = 3'b010; chnnl1 = 3'd4;
        tick();
        chk("lc_strt", 32'(strt_b), 32'd1);
        tick();                                   // first WAIT cycle
        for (int i = 0; i < 15; i++) tick();      // 16th WAIT cycle
        chk("lc_busy", 32'(busy_b), 32'd1);
        chk("lc_nodone", 32'(done_b), 32'd0);
        cnv_cmplt = 1'b1; res = 12'h123;
        tick();
        cnv_cmplt = 1'b0; res = '0;
        chk("lc_done", 32'(done_b), 32'b010);
        chk("lc_tmo",  32'(tmo_b),  32'd0);
        chk("lc_res",  32'(ro_b),   32'h123);
        req = 3'b000;
        tick();

        // no completion: timeout after 16 WAIT cycles
        req = 3'b100; chnnl2 = 3'd6;
        tick();
        chk("to_strt",  32'(strt_b), 32'd1);
        chk("to_chnnl", 32'(ch_b),   32'd6);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_done", 32'(done_b), 32'd0);
            tick();
        end
        chk("to_done", 32'(done_b), 32'b100);
        chk("to_tmo",  32'(tmo_b),  32'd1);
        chk("to_res",  32'(ro_b),   32'h123);
        req = 3'b000;
        tick();
        chk("to_idle", 32'(busy_b), 32'd0);
        chk("to_tmo_pulse", 32'(tmo_b), 32'd0);

        // reset during WAIT abandons the grant
        do_reset();
        req = 3'b001; chnnl0 = 3'd7;
        tick();
        tick();
        tick();
        chk("rw_busy", 32'(busy_a), 32'd1);
        rst = 1'b1; req = 3'b000;
        tick();
        rst = 1'b0;
        chk("rw_busy0", 32'(busy_a), 32'd0);
        chk("rw_done0", 32'(done_a), 32'd0);
        chk("rw_chnnl", 32'(ch_a),   32'd0);
        tick();
        chk("rw_done1", 32'(done_a), 32'd0);
        req = 3'b010; chnnl1 = 3'd2;
        tick();
        chk("rw_strt",  32'(strt_a), 32'd1);
        chk("rw_chnnl1",32'(ch_a),   32'd2);
        tick();
        cnv_cmplt = 1'b1; res = 12'h456;
        tick();
        cnv_cmplt = 1'b0; res = '0;
        chk("rw_done",  32'(done_a), 32'b010);
        req = 3'b000;
        tick();

        // stray completion in IDLE
        cnv_cmplt = 1'b1; res = 12'hFFF;
        tick();
        cnv_cmplt = 1'b0; res = '0;
        chk("st_done", 32'(done_a), 32'd0);
        chk("st_res",  32'(ro_a),   32'h456);
        chk("st_busy", 32'(busy_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/a2d_arb.md
A2D_ARB -- requirements
Module: a2d_arb

Interface
REQ-001 Parameter TMO_CYC, default 4096; WAIT-state cycles before a conversion is declared lost.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 req  input  3  per-requester conversion request; bit 0 IR scan, bit 1 battery, bit 2 aux.
REQ-005 chnnl0, chnnl1, chnnl2  input  3 each  A2D channel wanted by requester 0/1/2; held stable while its req is high.
REQ-006 cnv_cmplt  input  1  conversion-complete pulse from the shared A2D interface.
REQ-007 res  input  12  conversion result from the shared A2D interface; valid with cnv_cmplt.
REQ-008 strt_cnv  output  1  one-cycle start pulse to the shared A2D interface.
REQ-009 chnnl  output  3  channel to the shared A2D interface.
REQ-010 done  output  3  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 res_out  output  12  last captured result; valid while done is high; held afterwards.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tmo  output  1  one-cycle pulse coincident with done when the grant ended by timeout.

Function
REQ-014 FSM states: IDLE, START, WAIT, DONE.
REQ-015 IDLE: if req != 0, pick the winner round-robin; latch its index (gnt) and its chnnlN into chnnl; go to START. Otherwise stay.
REQ-016 Round-robin order: search begins at last_gnt+1 mod 3; last_gnt updates to gnt on leaving DONE.
REQ-017 START: strt_cnv=1 for exactly this cycle; go to WAIT.
REQ-018 WAIT: on cnv_cmplt, register res into res_out and go to DONE. Otherwise, when the timeout counter reaches TMO_CYC-1, set the timeout flag and go to DONE.
REQ-019 Timeout counter: clears on entering WAIT, increments each WAIT cycle, and has width clog2(TMO_CYC).
REQ-020 DONE: done[gnt]=1 and tmo=flag for this cycle; res_out is unchanged on timeout; go to IDLE unconditionally.
REQ-021 done, strt_cnv and tmo are Moore outputs decoded from registered state, gnt and flag.
REQ-022 chnnl is stable from START through DONE; it changes only on the IDLE->START transition.
REQ-023 Latency: req sampled high in IDLE cycle t gives strt_cnv in t+1. cnv_cmplt in cycle k gives done and res_out in k+1.
REQ-024 Requester protocol: the requester drops req on the edge that ends its done cycle. A req still high in IDLE is a new request.
REQ-025 req changes during START, WAIT or DONE are ignored; a grant is never revoked early.
REQ-026 cnv_cmplt outside WAIT is ignored; res_out is not updated.
REQ-027 If cnv_cmplt and the timeout condition coincide in WAIT, cnv_cmplt wins: res is captured and tmo=0.
REQ-028 Simultaneous requests are served one per grant cycle; the maximum wait is two other full grants.

Reset
REQ-029 rst (sampled at a clock edge) forces: state=IDLE, gnt=0, last_gnt=2 (requester 0 first), chnnl=0, res_out=0, timeout counter=0, flag=0.
REQ-030 With those values, strt_cnv=0, done=0, tmo=0 and busy=0 in the cycle after the reset edge.
REQ-031 Reset mid-operation abandons the grant with no done pulse; the A2D interface is reset by its own reset.

Structure
REQ-032 Package a2d_arb_pkg holds the state enum, NUM_REQ=3 and the 3-bit channel typedef.
REQ-033 The round-robin selection is a sub-module rr_pick: combinational, inputs req[2:0] and last_gnt, outputs gnt index and a valid flag.
REQ-034 The counter, state and result registers stay in a2d_arb.

Verification
REQ-035 After reset, req=3'b001, chnnl0=3'd5, model cnv_cmplt 40 cycles after strt_cnv with res=12'hA5C. Expect: strt_cnv one cycle after req, chnnl=5, done=3'b001 one cycle after cnv_cmplt, res_out=12'hA5C, tmo=0.
REQ-036 req=3'b111 held, each requester re-requesting after its done. Expect grant order 0,1,2,0,1,2, with each chnnl matching its requester.
REQ-037 TMO_CYC=16, model never returns cnv_cmplt. Expect done and tmo together exactly 16 WAIT cycles after entry, res_out unchanged, then IDLE.
REQ-038 cnv_cmplt on the last WAIT cycle before timeout, res=12'h123. Expect tmo=0 and res_out=12'h123.
REQ-039 Assert rst during WAIT. Expect IDLE next cycle, busy=0, no done pulse; a later req=3'b010 is served first by requester 1.
REQ-040 Stray cnv_cmplt in IDLE with res=12'hFFF. Expect no done and res_out unchanged.
